adm1278_poller: RTL and testbench
=================================

// Module: adm1278_poller
// PURPOSE
//  Autonomous PMBus telemetry sequencer for one ADM1278 hot-swap controller. Periodically reads
//  READ_VIN(0x88), READ_VOUT(0x8B), READ_IOUT(0x8C), READ_TEMPERATURE1(0x8D) through a shared
//  transaction-level I2C master and holds the latest 12-bit raw results for register readout.
//  Arbitrates the I2C master with one host requester (software path); host access only between poll sequences.
// PARAMETERS
//  I2C_ADR      7'h40      7-bit PMBus address of the ADM1278
//  POLL_PERIOD  1000000    clocks between automatic sequence starts (>=2)
//  TIMEOUT      65535      max clocks waiting for i2c_done_i per transaction before declaring error
// PORTS
//  clk_i         in   1   system clock (single clock domain)
//  rst_i         in   1   synchronous, active-high reset
//  enable_i      in   1   allow automatic periodic polling
//  poll_now_i    in   1   one-cycle pulse: request a sequence immediately (honoured even if enable_i=0)
//  host_req_i    in   1   host requests ownership of the I2C master
//  host_gnt_o    out  1   host owns the I2C master; poller issues nothing while high
//  i2c_valid_o   out  1   transaction request to I2C master (write cmd byte, Sr, read 2 bytes)
//  i2c_ready_i   in   1   master accepts request when i2c_valid_o & i2c_ready_i
//  i2c_adr_o     out  7   slave address (= I2C_ADR)
//  i2c_cmd_o     out  8   PMBus command code
//  i2c_done_i    in   1   one-cycle pulse: transaction complete
//  i2c_nack_i    in   1   qualifies i2c_done_i: transaction NACKed
//  i2c_data_i    in   16  read data, {second byte, first byte} (PMBus little-endian)
//  vin_o/vout_o/iout_o/temp_o  out 12 each  last good raw readings
//  valid_o       out  4   {temp,iout,vout,vin}: last read of that channel succeeded
//  update_o      out  1   one-cycle pulse at end of every completed sequence
//  err_cnt_o     out  8   saturating count of NACK + timeout events
//  busy_o        out  1   sequence in progress (state != IDLE/HOST)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; timer loaded with POLL_PERIOD-1; pending flag 0.
//  Timer: when enable_i=1 decrements each clock; at 0 pulses tick and reloads POLL_PERIOD-1.
//   enable_i=0 holds timer at POLL_PERIOD-1. pending <= 1 on tick or poll_now_i; cleared on leaving IDLE to ISSUE.
//  FSM: IDLE -> HOST if host_req_i (priority over pending); IDLE -> ISSUE if pending & !host_req_i, idx=0.
//   HOST: host_gnt_o=1 (registered, asserted the cycle after entering); exit to IDLE the cycle after host_req_i=0.
//     ticks/poll_now_i during HOST set pending; sequence starts on return to IDLE.
//   ISSUE: i2c_valid_o=1, i2c_cmd_o = {88,8B,8C,8D}[idx]; adr/cmd stable until accepted; on accept -> WAIT, wdog=0.
//   WAIT: i2c_done_i & !i2c_nack_i -> STORE. i2c_done_i & i2c_nack_i, or wdog==TIMEOUT-1 -> ERR.
//   STORE: chan[idx] <= i2c_data_i[11:0] (bits 15:12 ignored); valid_o[idx] <= 1; -> NEXT.
//   ERR: chan value held; valid_o[idx] <= 0; err_cnt_o += 1, saturating at 255; -> NEXT.
//   NEXT: idx==3 -> IDLE with update_o pulse for one cycle; else idx+1 -> ISSUE.
//  i2c_done_i outside WAIT ignored (late completion after timeout has no effect).
//  Host request never preempts an in-flight sequence; granted only at IDLE. host_gnt_o and i2c_valid_o never both 1.
//  enable_i falling mid-sequence: sequence completes; no new automatic start.
//  rst_i mid-transaction: i2c_valid_o low the next cycle; all results/valid/err cleared.
//  Latency: poll_now_i in IDLE -> i2c_valid_o high 2 cycles later (pending register, then ISSUE).
// TESTING
//  T1 model@0x40 (VIN=2351,VOUT=2340,IOUT=2429,TEMP=3293), poll_now_i -> cmds 88,8B,8C,8D in order;
//     vin_o=0x92F, vout_o=0x924, iout_o=0x97D, temp_o=0xCDD, valid_o=4'hF, one update_o pulse, err_cnt_o=0.
//  T2 POLL_PERIOD=100, enable_i=1 -> sequence starts every 100 clocks; enable_i=0 -> no further starts.
//  T3 NACK on 0x8C only -> iout_o keeps prior value, valid_o=4'b1011, err_cnt_o=1, 0x8D still issued.
//  T4 master never returns done, TIMEOUT=50 -> 4 errors, err_cnt_o=4, valid_o=0, update_o pulses;
//     256+ errors -> err_cnt_o stays 255.
//  T5 host_req_i asserted mid-sequence -> host_gnt_o only after update_o; tick during HOST -> sequence
//     starts right after host_req_i drops; assert host_gnt_o & i2c_valid_o never both high.
//  T6 rst_i during WAIT -> outputs zero next cycle; subsequent poll_now_i runs a clean full sequence.

Source files
------------

// File: rtl/adm1278_poller.sv
// PMBus telemetry sequencer for one ADM1278: periodically reads VIN/VOUT/IOUT/TEMP1 through a
// shared transaction-level I2C master, and hands that master to a host requester between sequences.
module adm1278_poller #(
  parameter logic [6:0] I2C_ADR     = 7'h40,
  parameter int         POLL_PERIOD = 1000000,
  parameter int         TIMEOUT     = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        poll_now_i,
  input  logic        host_req_i,
  output logic        host_gnt_o,
  output logic        i2c_valid_o,
  input  logic        i2c_ready_i,
  output logic [6:0]  i2c_adr_o,
  output logic [7:0]  i2c_cmd_o,
  input  logic        i2c_done_i,
  input  logic        i2c_nack_i,
  input  logic [15:0] i2c_data_i,
  output logic [11:0] vin_o,
  output logic [11:0] vout_o,
  output logic [11:0] iout_o,
  output logic [11:0] temp_o,
  output logic [3:0]  valid_o,
  output logic        update_o,
  output logic [7:0]  err_cnt_o,
  output logic        busy_o
);
  localparam int TW = $clog2(POLL_PERIOD + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] RELOAD   = TW'(POLL_PERIOD - 1);
  localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, HOST, ISSUE, WAIT, STORE, ERR, NEXT} state_t;

  state_t           state_q;
  logic [TW-1:0]    timer_q;
  logic [WW-1:0]    wdog_q;
  logic             pending_q;
  logic [1:0]       idx_q;
  logic             valid_q, gnt_q, update_q;
  logic [7:0]       cmd_q, err_q;
  logic [11:0]      rdata_q;
  logic [3:0][11:0] chan_q;
  logic [3:0]       chv_q;
  logic             tick;
  logic             unused_hi;

  // Upper data nibble carries no measurement bits on the ADM1278.
  assign unused_hi = ^i2c_data_i[15:12];

  assign tick = enable_i && (timer_q == '0);

  function automatic logic [7:0] cmd_of(input logic [1:0] i);
    case (i)
      2'd0:    cmd_of = 8'h88;
      2'd1:    cmd_of = 8'h8B;
      2'd2:    cmd_of = 8'h8C;
      default: cmd_of = 8'h8D;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      timer_q   <= RELOAD;
      wdog_q    <= '0;
      pending_q <= 1'b0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      gnt_q     <= 1'b0;
      update_q  <= 1'b0;
      cmd_q     <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      chan_q    <= '0;
      chv_q     <= '0;
    end else begin
      update_q <= 1'b0;
      if (!enable_i || timer_q == '0) timer_q <= RELOAD;
      else                            timer_q <= timer_q - 1'b1;

      case (state_q)
        IDLE: begin
          if (host_req_i) state_q <= HOST;
          else if (pending_q) begin
            state_q   <= ISSUE;
            idx_q     <= 2'd0;
            valid_q   <= 1'b1;
            cmd_q     <= cmd_of(2'd0);
            pending_q <= 1'b0;
          end
        end
        HOST: begin
          if (!host_req_i) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
          end else gnt_q <= 1'b1;
        end
        ISSUE: begin
          if (i2c_ready_i) begin
            valid_q <= 1'b0;
            wdog_q  <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // A completion in the same cycle as the watchdog expiry still counts as done.
          if (i2c_done_i && !i2c_nack_i) begin
            rdata_q <= i2c_data_i[11:0];
            state_q <= STORE;
          end else if (i2c_done_i || wdog_q == WDOG_MAX) state_q <= ERR;
          else wdog_q <= wdog_q + 1'b1;
        end
        STORE: begin
          chan_q[idx_q] <= rdata_q;
          chv_q[idx_q]  <= 1'b1;
          state_q       <= NEXT;
        end
        ERR: begin
          chv_q[idx_q] <= 1'b0;
          if (err_q != 8'hFF) err_q <= err_q + 1'b1;
          state_q <= NEXT;
        end
        NEXT: begin
          if (idx_q == 2'd3) begin
            state_q  <= IDLE;
            update_q <= 1'b1;
          end else begin
            idx_q   <= idx_q + 1'b1;
            cmd_q   <= cmd_of(idx_q + 1'b1);
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A new request always survives, even in the cycle that consumes the old one.
      if (tick || poll_now_i) pending_q <= 1'b1;
    end
  end

  assign host_gnt_o  = gnt_q;
  assign i2c_valid_o = valid_q;
  assign i2c_adr_o   = I2C_ADR;
  assign i2c_cmd_o   = cmd_q;
  assign vin_o       = chan_q[0];
  assign vout_o      = chan_q[1];
  assign iout_o      = chan_q[2];
  assign temp_o      = chan_q[3];
  assign valid_o     = chv_q;
  assign update_o    = update_q;
  assign err_cnt_o   = err_q;
  assign busy_o      = (state_q != IDLE) && (state_q != HOST);
endmodule

// File: tb/tb_adm1278_poller.sv
// Bench for adm1278_poller: PMBus slave model with a command scoreboard, a vector table for
// single-sequence results, and hand sequences for periodic polling, host arbitration, timeout and reset.
module tb_adm1278_poller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, enable_i, poll_now_i, host_req_i, host_gnt_o;
  logic        i2c_valid_o, i2c_ready_i, i2c_done_i, i2c_nack_i;
  logic [6:0]  i2c_adr_o;
  logic [7:0]  i2c_cmd_o, err_cnt_o;
  logic [15:0] i2c_data_i;
  logic [11:0] vin_o, vout_o, iout_o, temp_o;
  logic [3:0]  valid_o;
  logic        update_o, busy_o;

  adm1278_poller #(.I2C_ADR(7'h40), .POLL_PERIOD(100), .TIMEOUT(50)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .poll_now_i(poll_now_i),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .i2c_valid_o(i2c_valid_o),
    .i2c_ready_i(i2c_ready_i), .i2c_adr_o(i2c_adr_o), .i2c_cmd_o(i2c_cmd_o),
    .i2c_done_i(i2c_done_i), .i2c_nack_i(i2c_nack_i), .i2c_data_i(i2c_data_i),
    .vin_o(vin_o), .vout_o(vout_o), .iout_o(iout_o), .temp_o(temp_o), .valid_o(valid_o),
    .update_o(update_o), .err_cnt_o(err_cnt_o), .busy_o(busy_o));

  int checks = 0, failures = 0;
  int cyc = 0, upd_cnt = 0, acc_cnt = 0;
  int starts_q[$];
  logic [7:0] exp_cmd_q[$];

  logic [3:0][15:0] m_data;
  logic [3:0]       m_nack;
  bit               m_hang;

  typedef struct {
    logic [3:0][15:0] data;
    logic [3:0]       nack;
    logic [3:0][11:0] exp_chan;
    logic [3:0]       exp_valid;
    logic [7:0]       exp_err;
  } vec_t;
  vec_t vec[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_update(input int max, input string name);
    bit seen = 0;
    for (int n = 0; n < max && !seen; n++) begin
      @(negedge clk);
      if (update_o) seen = 1;
    end
    chk(name, 32'(seen), 1);
  endtask

  task automatic pulse_poll();
    @(negedge clk) poll_now_i = 1'b1;
    @(negedge clk) poll_now_i = 1'b0;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (update_o) upd_cnt++;
  end

  always @(negedge clk)
    if (host_gnt_o) chk("gnt_excl", 32'(i2c_valid_o), 0);

  // Slave model: scoreboard the command order, then answer after a short random delay.
  initial begin
    logic [7:0] c;
    int k;
    i2c_done_i = 1'b0; i2c_nack_i = 1'b0; i2c_data_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_i && i2c_valid_o && i2c_ready_i) begin
        c = i2c_cmd_o;
        if (exp_cmd_q.size() == 0) begin
          exp_cmd_q.push_back(8'h88); exp_cmd_q.push_back(8'h8B);
          exp_cmd_q.push_back(8'h8C); exp_cmd_q.push_back(8'h8D);
        end
        chk("cmd_order", 32'(c), 32'(exp_cmd_q.pop_front()));
        chk("adr", 32'(i2c_adr_o), 32'h40);
        acc_cnt++;
        if (c == 8'h88) starts_q.push_back(cyc);
        case (c)
          8'h88:   k = 0;
          8'h8B:   k = 1;
          8'h8C:   k = 2;
          default: k = 3;
        endcase
        if (!m_hang) begin
          @(negedge clk);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          i2c_data_i = m_data[k]; i2c_nack_i = m_nack[k]; i2c_done_i = 1'b1;
          @(negedge clk);
          i2c_done_i = 1'b0; i2c_nack_i = 1'b0; i2c_data_i = 16'($urandom);
        end
      end
    end
  end

  initial begin
    int n, u0, a0, a1;
    vec[0] = '{data: {16'h0CDD, 16'h097D, 16'h0924, 16'h092F}, nack: 4'b0000,
               exp_chan: {12'hCDD, 12'h97D, 12'h924, 12'h92F}, exp_valid: 4'hF, exp_err: 8'd0};
    vec[1] = '{data: {16'h3ABC, 16'h5789, 16'hA456, 16'hF123}, nack: 4'b0000,
               exp_chan: {12'hABC, 12'h789, 12'h456, 12'h123}, exp_valid: 4'hF, exp_err: 8'd0};
    vec[2] = '{data: {16'h0444, 16'h0333, 16'h0222, 16'h0111}, nack: 4'b0100,
               exp_chan: {12'h444, 12'h789, 12'h222, 12'h111}, exp_valid: 4'b1011, exp_err: 8'd1};
    vec[3] = '{data: {16'h0666, 16'h0555, 16'h0000, 16'h0FFF}, nack: 4'b0000,
               exp_chan: {12'h666, 12'h555, 12'h000, 12'hFFF}, exp_valid: 4'hF, exp_err: 8'd1};
    vec[4] = '{data: {16'h0DDD, 16'h0CCC, 16'h0BBB, 16'h0AAA}, nack: 4'b1001,
               exp_chan: {12'h666, 12'hCCC, 12'hBBB, 12'hFFF}, exp_valid: 4'b0110, exp_err: 8'd3};

    rst_i = 1'b1; enable_i = 1'b0; poll_now_i = 1'b0; host_req_i = 1'b0; i2c_ready_i = 1'b1;
    m_hang = 0; m_nack = '0; m_data = vec[0].data;
    repeat (3) @(negedge clk);
    chk("rst_vin", 32'(vin_o), 0);       chk("rst_vout", 32'(vout_o), 0);
    chk("rst_iout", 32'(iout_o), 0);     chk("rst_temp", 32'(temp_o), 0);
    chk("rst_valid", 32'(valid_o), 0);   chk("rst_err", 32'(err_cnt_o), 0);
    chk("rst_upd", 32'(update_o), 0);    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_i2cv", 32'(i2c_valid_o), 0); chk("rst_gnt", 32'(host_gnt_o), 0);
    rst_i = 1'b0;

    // Table: one poll_now sequence per vector, including the 2-cycle start latency.
    for (int i = 0; i < 5; i++) begin
      m_data = vec[i].data; m_nack = vec[i].nack; u0 = upd_cnt;
      @(negedge clk) poll_now_i = 1'b1;
      @(negedge clk) poll_now_i = 1'b0;
      chk("lat_cyc1_valid", 32'(i2c_valid_o), 0);
      @(negedge clk);
      chk("lat_cyc2_valid", 32'(i2c_valid_o), 1);
      chk("lat_cyc2_busy", 32'(busy_o), 1);
      wait_update(200, "vec_update");
      repeat (3) @(negedge clk);
      chk("vec_vin", 32'(vin_o), 32'(vec[i].exp_chan[0]));
      chk("vec_vout", 32'(vout_o), 32'(vec[i].exp_chan[1]));
      chk("vec_iout", 32'(iout_o), 32'(vec[i].exp_chan[2]));
      chk("vec_temp", 32'(temp_o), 32'(vec[i].exp_chan[3]));
      chk("vec_valid", 32'(valid_o), 32'(vec[i].exp_valid));
      chk("vec_err", 32'(err_cnt_o), 32'(vec[i].exp_err));
      chk("vec_one_update", 32'(upd_cnt - u0), 1);
    end

    // Periodic polling every 100 clocks, then stop on enable_i=0.
    m_nack = '0; starts_q.delete();
    @(negedge clk) enable_i = 1'b1;
    repeat (330) @(negedge clk);
    enable_i = 1'b0;
    repeat (60) @(negedge clk);
    n = starts_q.size();
    chk("per_starts", 32'(n), 3);
    if (n >= 3) begin
      chk("per_interval1", 32'(starts_q[1] - starts_q[0]), 100);
      chk("per_interval2", 32'(starts_q[2] - starts_q[1]), 100);
    end
    repeat (300) @(negedge clk);
    chk("per_stopped", 32'(starts_q.size()), 32'(n));
    chk("per_vin", 32'(vin_o), 32'hAAA);

    // Host request mid-sequence is granted only after the sequence ends.
    a0 = acc_cnt;
    pulse_poll();
    for (int w = 0; w < 20 && acc_cnt == a0; w++) @(negedge clk);
    chk("host_seq_started", 32'(acc_cnt > a0), 1);
    host_req_i = 1'b1;
    wait_update(200, "host_update");
    chk("host_no_gnt_at_update", 32'(host_gnt_o), 0);
    for (int w = 0; w < 10 && !host_gnt_o; w++) @(negedge clk);
    chk("host_gnt", 32'(host_gnt_o), 1);
    a1 = acc_cnt;
    pulse_poll();
    repeat (10) @(negedge clk);
    chk("host_hold_acc", 32'(acc_cnt), 32'(a1));
    chk("host_hold_i2cv", 32'(i2c_valid_o), 0);
    host_req_i = 1'b0;
    @(negedge clk);
    chk("host_release_gnt", 32'(host_gnt_o), 0);
    chk("host_release_i2cv", 32'(i2c_valid_o), 0);
    @(negedge clk);
    chk("host_pending_start", 32'(i2c_valid_o), 1);
    wait_update(200, "host_pending_update");
    repeat (2) @(negedge clk);

    // Slave never answers: four timeouts per sequence, then saturation of the error count.
    m_hang = 1;
    pulse_poll();
    wait_update(400, "to_update");
    repeat (2) @(negedge clk);
    chk("to_err", 32'(err_cnt_o), 7);
    chk("to_valid", 32'(valid_o), 0);
    chk("to_vin_held", 32'(vin_o), 32'hAAA);
    chk("to_temp_held", 32'(temp_o), 32'hDDD);
    for (int s = 0; s < 63; s++) begin
      pulse_poll();
      wait_update(400, "sat_update");
      @(negedge clk);
    end
    chk("sat_err", 32'(err_cnt_o), 255);

    // Reset while waiting on the master, then a clean sequence.
    pulse_poll();
    repeat (6) @(negedge clk);
    chk("rst_mid_busy", 32'(busy_o), 1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rstm_i2cv", 32'(i2c_valid_o), 0); chk("rstm_vin", 32'(vin_o), 0);
    chk("rstm_temp", 32'(temp_o), 0);      chk("rstm_valid", 32'(valid_o), 0);
    chk("rstm_err", 32'(err_cnt_o), 0);    chk("rstm_busy", 32'(busy_o), 0);
    rst_i = 1'b0;
    exp_cmd_q.delete();
    m_hang = 0; m_nack = '0; m_data = vec[0].data;
    pulse_poll();
    wait_update(200, "clean_update");
    repeat (2) @(negedge clk);
    chk("clean_vin", 32'(vin_o), 32'h92F);   chk("clean_vout", 32'(vout_o), 32'h924);
    chk("clean_iout", 32'(iout_o), 32'h97D); chk("clean_temp", 32'(temp_o), 32'hCDD);
    chk("clean_valid", 32'(valid_o), 32'hF); chk("clean_err", 32'(err_cnt_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
